// File: rtl/blake2_io_pkg.sv
// Shared command/state types and sizing helpers for the blake2 host interface.
package blake2_io_pkg;

  typedef enum logic [1:0] {
    CMD_CONF  = 2'd0,
    CMD_START = 2'd1,
    CMD_DATA  = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONF  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAD   = 3'd4,
    ST_WAIT  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam int BLOCK_BYTES_DEF = 64;
  localparam int IDX_W_DEF       = $clog2(BLOCK_BYTES_DEF);

  // kk, nn, then ll little-endian
  function automatic int conf_bytes(input int ll_w);
    return 2 + ll_w / 8;
  endfunction

endpackage

// File: rtl/blake2_io_framer.sv
// Block framer: byte/block position, T/NB from kk/ll, idx/first/last tagging.
// With ZERO_PAD_EN, host_end flags the last host-supplied byte (byte T).
module blake2_io_framer import blake2_io_pkg::*; #(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int LL_W        = 64,
  localparam int IDX_W      = $clog2(BLOCK_BYTES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             adv,
  input  logic [7:0]       byte_in,
  input  logic [7:0]       kk,
  input  logic [LL_W-1:0]  ll,
  output logic             last_byte,
`ifdef ZERO_PAD_EN
  output logic             host_end,
`endif
  output logic             data_v,
  output logic [7:0]       data,
  output logic [IDX_W-1:0] idx,
  output logic             first,
  output logic             last
);

  localparam int BLK_W = LL_W - IDX_W + 1;
  localparam int CNT_W = LL_W + 1;

  logic [CNT_W-1:0] t_raw, t_bytes;
  logic [BLK_W-1:0] nb, blk;
  logic [IDX_W-1:0] pos;
  logic             last_blk;

  // Key block counts as one extra block; an empty message still hashes one block.
  always_comb begin
    t_raw     = {1'b0, ll} + ((kk != 8'd0) ? CNT_W'(BLOCK_BYTES) : '0);
    t_bytes   = (t_raw == '0) ? CNT_W'(BLOCK_BYTES) : t_raw;
    nb        = BLK_W'((t_bytes + CNT_W'(BLOCK_BYTES - 1)) >> IDX_W);
    last_blk  = (blk == nb - BLK_W'(1));
    last_byte = last_blk && (pos == '1);
  end

`ifdef ZERO_PAD_EN
  assign host_end = ({blk, pos} == t_bytes - CNT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_v <= 1'b0;
      data   <= '0;
      idx    <= '0;
      first  <= 1'b0;
      last   <= 1'b0;
      blk    <= '0;
      pos    <= '0;
    end else begin
      data_v <= adv;
      if (clear) begin
        blk <= '0;
        pos <= '0;
      end else if (adv) begin
        data  <= byte_in;
        idx   <= pos;
        first <= (blk == '0);
        last  <= last_blk;
        pos   <= pos + IDX_W'(1);
        if (pos == '1) blk <= blk + BLK_W'(1);
      end
    end
  end

endmodule

// File: rtl/blake2_io_intf_v2.sv
// Host command interface in front of the blake2 core: CONF/START/DATA decode,
// block framing and digest return. Define ZERO_PAD_EN for hardware zero padding.
module blake2_io_intf_v2 import blake2_io_pkg::*; #(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int LL_W        = 64,
  parameter int KK_MAX      = 32,
  parameter int NN_MAX      = 32,
  localparam int IDX_W      = $clog2(BLOCK_BYTES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [1:0]       cmd_i,
  input  logic [7:0]       data_i,
  output logic             ready_o,
  input  logic             core_ready_i,
  output logic [7:0]       kk_o,
  output logic [7:0]       nn_o,
  output logic [LL_W-1:0]  ll_o,
  output logic             data_v_o,
  output logic [7:0]       data_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic             block_first_o,
  output logic             block_last_o,
  input  logic             hash_v_i,
  input  logic [7:0]       hash_i,
  output logic             hash_v_o,
  output logic [7:0]       hash_o,
  output logic             hash_done_o,
  output logic             err_o
);

  localparam int CONF_N = conf_bytes(LL_W);

  state_e     state, state_nxt;
  cmd_e       cmd;
  logic       is_conf, is_start, is_data, is_rsvd;
  logic       accept, pad_emit, start_ev, conf_last, cfg_bad, fr_last_byte;
  logic [7:0] conf_cnt, hash_cnt;
`ifdef ZERO_PAD_EN
  logic       fr_host_end;
`endif

  assign cmd       = cmd_e'(cmd_i);
  assign is_conf   = valid_i && (cmd == CMD_CONF);
  assign is_start  = valid_i && (cmd == CMD_START);
  assign is_data   = valid_i && (cmd == CMD_DATA);
  assign is_rsvd   = valid_i && (cmd == CMD_RSVD);
  assign conf_last = (conf_cnt == 8'(CONF_N - 1));
  assign cfg_bad   = (kk_o > 8'(KK_MAX)) || (nn_o == 8'd0) || (nn_o > 8'(NN_MAX));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (is_conf && state != ST_CONF) begin
      state_nxt = ST_CONF;
    end else begin
      case (state)
        ST_IDLE:  ;
        ST_CONF:  if (is_conf && conf_last) state_nxt = cfg_bad ? ST_IDLE : ST_ARMED;
        ST_ARMED: if (is_start) state_nxt = ST_DATA;
        ST_DATA: if (accept) begin
          if (fr_last_byte) state_nxt = ST_WAIT;
`ifdef ZERO_PAD_EN
          else if (fr_host_end) state_nxt = ST_PAD;
`endif
        end
`ifdef ZERO_PAD_EN
        ST_PAD:   if (pad_emit && fr_last_byte) state_nxt = ST_WAIT;
`endif
        ST_WAIT:  if (hash_v_i && hash_cnt == nn_o - 8'd1) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o     = (state == ST_DATA) && core_ready_i;
    accept      = is_data && ready_o;
    start_ev    = is_start && (state == ST_ARMED);
    hash_done_o = (state == ST_DONE);
    pad_emit    = 1'b0;
`ifdef ZERO_PAD_EN
    pad_emit    = (state == ST_PAD) && core_ready_i;
`endif
  end

  // Config latch, sticky error and digest return path.
  always_ff @(posedge clk) begin
    if (reset) begin
      kk_o     <= '0;
      nn_o     <= '0;
      ll_o     <= '0;
      err_o    <= 1'b0;
      conf_cnt <= '0;
      hash_cnt <= '0;
      hash_v_o <= 1'b0;
      hash_o   <= '0;
    end else begin
      hash_v_o <= 1'b0;
      if (is_conf) begin
        if (state != ST_CONF) begin
          kk_o     <= data_i;
          conf_cnt <= 8'd1;
          err_o    <= 1'b0;
        end else begin
          if (conf_cnt == 8'd1) nn_o <= data_i;
          else                  ll_o <= LL_W'({data_i, ll_o} >> 8);
          conf_cnt <= conf_cnt + 8'd1;
          if (conf_last && cfg_bad) err_o <= 1'b1;
        end
      end
      if ((is_start && state != ST_ARMED) || (is_data && state != ST_DATA) || is_rsvd)
        err_o <= 1'b1;
      if (state == ST_WAIT) begin
        if (hash_v_i) begin
          hash_v_o <= 1'b1;
          hash_o   <= hash_i;
          hash_cnt <= hash_cnt + 8'd1;
        end
      end else begin
        hash_cnt <= '0;
      end
    end
  end

  blake2_io_framer #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .LL_W        (LL_W)
  ) u_framer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ev),
    .adv       (accept || pad_emit),
    .byte_in   (accept ? data_i : 8'h00),
    .kk        (kk_o),
    .ll        (ll_o),
    .last_byte (fr_last_byte),
`ifdef ZERO_PAD_EN
    .host_end  (fr_host_end),
`endif
    .data_v    (data_v_o),
    .data      (data_o),
    .idx       (data_idx_o),
    .first     (block_first_o),
    .last      (block_last_o)
  );

endmodule
